// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Central stall/flush sequencer for the 20-bit five-stage pipeline.
// It resolves three kinds of events, in this priority order:
//   - a multicycle data-memory wait (busy);
//   - a taken branch or jump redirect resolved in MEM (redir);
//   - a load-use hazard between EX and ID (lu).
// From these it drives the pipeline-register enables and flushes and the PC source select.
//
// Ports
//   clk, rst_n            clock and asynchronous active-low reset
//   id_rs, id_rt          source registers of the instruction in ID
//   id_uses_rt            the instruction in ID reads rt
//   ex_rd                 destination register of the instruction in EX
//   ex_memread            the instruction in EX is a load
//   ex_regwrite           the instruction in EX writes a register
//   mem_branch, mem_zero  branch in MEM and its zero flag
//   mem_j, mem_jmem       jump and register/memory jump in MEM
//   mem_req, mem_ready    data-memory access in MEM and its completion
//   pc_en, ifid_en,
//   idex_en, exmem_en     load enables for the PC and the pipeline registers
//   ifid_flush,
//   idex_flush,
//   exmem_flush           load a bubble into the pipeline register
//   pc_src                0=PC+1, 1=branch target, 2=jump target, 3=jmem target
//   state                 current FSM state (RUN/LU_STALL/FLUSH/MEM_WAIT)
//   mem_timeout           sticky flag: the memory wait reached TO_CYC cycles
//   stall_cnt, flush_cnt  performance counters
//
// Optional feature: when the macro HAZ_PERF_EN is defined, the stall and redirect
// performance counters are built. When it is not defined, both counters read as zero.
module pipe_hazard_ctrl #(
  parameter int REG_AW = 4,
  parameter int TO_CYC = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_regwrite,
  input  logic              mem_branch,
  input  logic              mem_zero,
  input  logic              mem_j,
  input  logic              mem_jmem,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              idex_en,
  output logic              exmem_en,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic              exmem_flush,
  output logic [1:0]        pc_src,
  output logic [1:0]        state,
  output logic              mem_timeout,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } state_e;

  localparam logic [7:0] TO_LIM = 8'(TO_CYC);

  state_e     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;

  logic busy, redir, lu, take_redir, take_lu;

  assign busy  = mem_req & ~mem_ready;
  assign redir = (mem_branch & mem_zero) | mem_j | mem_jmem;
  assign lu    = ex_memread & ex_regwrite & (ex_rd != '0) &
                 ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));

  // The cycle right after a redirect is in FLUSH.
  // In that cycle the MEM and EX bits describe squashed instructions, so redirect and load-use are ignored.
  // A memory wait is still honoured.
  assign take_redir = ~busy & redir & (state_q != FLUSH);
  assign take_lu    = ~busy & ~redir & lu & (state_q != FLUSH);

  // Zero-cycle control decision made from the current state and the stage bits.
  // Reset overrides everything: the pipeline holds with bubbles loaded.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pc_src      = 2'd0;
    state_d     = RUN;
    if (busy) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      state_d  = MEM_WAIT;
    end else if (take_redir) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      if (mem_jmem)   pc_src = 2'd3;
      else if (mem_j) pc_src = 2'd2;
      else            pc_src = 2'd1;
      state_d = FLUSH;
    end else if (take_lu) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
      state_d    = LU_STALL;
    end
    if (!rst_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      pc_src      = 2'd0;
    end
  end

  // Memory-wait watchdog.
  // The wait counter only counts while the FSM is parked in MEM_WAIT and memory is still busy.
  // It saturates at TO_LIM. Reaching TO_LIM latches the sticky timeout flag.
  always_comb begin
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    if (state_q == MEM_WAIT && busy) begin
      wait_cnt_d = (wait_cnt_q == TO_LIM) ? wait_cnt_q : wait_cnt_q + 8'd1;
      if (wait_cnt_d == TO_LIM) mem_timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign state       = state_q;
  assign mem_timeout = mem_timeout_q;

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  // Saturating performance counters.
  // The stall counter counts cycles with the PC held. The flush counter counts redirect cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en && stall_cnt_q != '1) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (take_redir && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
